// File: rtl/perceptron_sequencer_if.sv
// Command and result port bundle for the perceptron sequencer.
// Master issues commands and consumes results; slave is the sequencer itself.
// Backpressure: commands move only on cmd_valid & cmd_ready; results are unthrottled pulses.
interface perceptron_sequencer_if #(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = 8
);
  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int ACC_W = W_WIDTH + $clog2(N_IN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [IDX_W-1:0]   cmd_idx;
  logic [W_WIDTH-1:0] cmd_data;
  logic [N_IN-1:0]    cmd_x;
  logic               cmd_label;
  logic               res_valid;
  logic               res_y;
  logic [ACC_W-1:0]   res_sum;
  logic               res_upd;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_x, cmd_label,
    input  cmd_ready, res_valid, res_y, res_sum, res_upd, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_x, cmd_label,
    output cmd_ready, res_valid, res_y, res_sum, res_upd, busy
  );
endinterface

// File: rtl/perceptron_sequencer.sv
// Perceptron weight store and command sequencer sharing one adder across all terms.
// Latency: LOAD/CLEAR same edge; INFER/TRAIN result N_IN+1 edges after accept, TRAIN update N_IN+1 more.
// Backpressure: cmd_ready only in IDLE with ena high; ena low freezes everything.
module perceptron_sequencer #(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = 8,
  parameter int LR      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  perceptron_sequencer_if.slave io
);
  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int ACC_W = W_WIDTH + $clog2(N_IN + 1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INFER = 2'b01;
  localparam logic [1:0] OP_TRAIN = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic signed [W_WIDTH:0] LR_S  = (W_WIDTH + 1)'(LR);
  localparam logic signed [W_WIDTH:0] W_MAX = (W_WIDTH + 1)'((1 << (W_WIDTH - 1)) - 1);
  localparam logic signed [W_WIDTH:0] W_MIN = ~W_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_UPDATE} state_t;

  state_t state, state_nxt;

  logic signed [W_WIDTH-1:0] w [N_IN];
  logic signed [W_WIDTH-1:0] bias;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic [N_IN-1:0]           x_q;
  logic                      label_q;
  logic                      train_q;

  logic                      res_valid_q;
  logic                      res_y_q;
  logic                      res_upd_q;
  logic signed [ACC_W-1:0]   res_sum_q;

  logic                      accept;
  logic                      last_accum;
  logic                      last_update;
  logic                      acc_pos;
  logic                      upd_req;
  logic signed [W_WIDTH-1:0] w_sel;
  logic                      x_sel;

  // One learning step with clamping to the signed weight range.
  function automatic logic signed [W_WIDTH-1:0] sat_step(
    input logic signed [W_WIDTH-1:0] v,
    input logic                      up
  );
    logic signed [W_WIDTH:0] s;
    s = up ? ((W_WIDTH + 1)'(v) + LR_S) : ((W_WIDTH + 1)'(v) - LR_S);
    if (s > W_MAX)
      sat_step = W_MAX[W_WIDTH-1:0];
    else if (s < W_MIN)
      sat_step = W_MIN[W_WIDTH-1:0];
    else
      sat_step = s[W_WIDTH-1:0];
  endfunction

  always_comb begin
    w_sel = '0;
    x_sel = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (idx == IDX_W'(k)) begin
        w_sel = w[k];
        x_sel = x_q[k];
      end
    end
  end

  assign acc_pos     = !acc[ACC_W-1] && (acc != '0);
  assign upd_req     = train_q && (acc_pos != label_q);
  assign last_accum  = (idx == IDX_W'(N_IN - 1));
  assign last_update = (idx == IDX_W'(N_IN));
  assign accept      = io.cmd_valid & io.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    io.cmd_ready = 1'b0;
    io.busy      = (state != S_IDLE);
    if (ena) begin
      case (state)
        S_IDLE: begin
          io.cmd_ready = 1'b1;
          if (io.cmd_valid && (io.cmd_op == OP_INFER || io.cmd_op == OP_TRAIN))
            state_nxt = S_ACCUM;
        end
        S_ACCUM:  if (last_accum) state_nxt = S_DECIDE;
        S_DECIDE: state_nxt = upd_req ? S_UPDATE : S_IDLE;
        S_UPDATE: if (last_update) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) w[k] <= '0;
      bias        <= '0;
      acc         <= '0;
      idx         <= '0;
      x_q         <= '0;
      label_q     <= 1'b0;
      train_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= 1'b0;
      res_upd_q   <= 1'b0;
      res_sum_q   <= '0;
    end else if (!ena) begin
      // Drop the pending pulse so it cannot reappear when ena returns.
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (io.cmd_op)
              OP_LOAD: begin
                for (int k = 0; k < N_IN; k++)
                  if (io.cmd_idx == IDX_W'(k)) w[k] <= io.cmd_data;
                if (io.cmd_idx == IDX_W'(N_IN)) bias <= io.cmd_data;
              end
              OP_CLEAR: begin
                for (int k = 0; k < N_IN; k++) w[k] <= '0;
                bias <= '0;
              end
              default: begin
                x_q     <= io.cmd_x;
                label_q <= io.cmd_label;
                train_q <= (io.cmd_op == OP_TRAIN);
                acc     <= ACC_W'(bias);
                idx     <= '0;
              end
            endcase
          end
        end
        S_ACCUM: begin
          if (x_sel) acc <= acc + ACC_W'(w_sel);
          idx <= idx + IDX_W'(1);
        end
        S_DECIDE: begin
          res_valid_q <= 1'b1;
          res_sum_q   <= acc;
          res_y_q     <= acc_pos;
          res_upd_q   <= upd_req;
          idx         <= '0;
        end
        S_UPDATE: begin
          // Weights first (gated by the latched x), bias on the final step.
          for (int k = 0; k < N_IN; k++)
            if (idx == IDX_W'(k) && x_q[k]) w[k] <= sat_step(w[k], label_q);
          if (last_update) bias <= sat_step(bias, label_q);
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign io.res_valid = res_valid_q & ena;
  assign io.res_y     = res_y_q;
  assign io.res_sum   = res_sum_q;
  assign io.res_upd   = res_upd_q;
endmodule

// File: tb/tb_perceptron_sequencer.sv
// Bench for perceptron_sequencer: directed vector table, random commands against a
// behavioural weight-store model, and hand sequences for reset and ena stalls.
module tb_perceptron_sequencer;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INFER = 2'b01;
  localparam logic [1:0] OP_TRAIN = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  perceptron_sequencer_if #(.N_IN(4), .W_WIDTH(8)) io ();

  perceptron_sequencer #(.N_IN(4), .W_WIDTH(8), .LR(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .io   (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rv_cnt = 0;

  always @(posedge clk) begin
    if (io.cmd_valid && io.cmd_ready) acc_cnt <= acc_cnt + 1;
    if (io.res_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer weights, bias and the perceptron rule.
  int mw[4];
  int mb;

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_cmd(input logic [1:0] op, input int idx, input logic [7:0] data,
                           input logic [3:0] x, input logic lbl,
                           output int s, output int y, output int u);
    int d;
    s = 0; y = 0; u = 0;
    case (op)
      OP_LOAD: begin
        if (idx < 4) mw[idx] = int'($signed(data));
        else if (idx == 4) mb = int'($signed(data));
      end
      OP_CLEAR: begin
        for (int k = 0; k < 4; k++) mw[k] = 0;
        mb = 0;
      end
      default: begin
        s = mb;
        for (int k = 0; k < 4; k++) if (x[k]) s += mw[k];
        y = (s > 0) ? 1 : 0;
        u = (op == OP_TRAIN && y != int'(lbl)) ? 1 : 0;
        if (u == 1) begin
          d = lbl ? 1 : -1;
          for (int k = 0; k < 4; k++) if (x[k]) mw[k] = clamp8(mw[k] + d);
          mb = clamp8(mb + d);
        end
      end
    endcase
  endtask

  // Issue one command; for INFER/TRAIN also collect the result, its latency
  // (edges after accept) and how long cmd_ready stays low after it.
  task automatic exec(input logic [1:0] op, input int idx, input logic [7:0] data,
                      input logic [3:0] x, input logic lbl,
                      output int s, output int y, output int u,
                      output int lat, output int gap);
    int n;
    logic r0;
    s = 0; y = 0; u = 0; lat = -1; gap = -1;
    @(negedge clk);
    io.cmd_op = op; io.cmd_idx = 3'(idx); io.cmd_data = data;
    io.cmd_x = x; io.cmd_label = lbl; io.cmd_valid = 1'b1;
    n = 0;
    while (!io.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.cmd_ready) begin
      check("accept_timeout", 0, 1);
      io.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    if (op == OP_INFER || op == OP_TRAIN) begin
      lat = 0;
      while (!io.res_valid && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      if (!io.res_valid) begin
        check("result_timeout", 0, 1);
        return;
      end
      s = int'($signed(io.res_sum));
      y = int'(io.res_y);
      u = int'(io.res_upd);
      r0 = io.cmd_ready;
      @(posedge clk);
      #1;
      check("pulse_width", int'(io.res_valid), 0);
      gap = r0 ? 0 : 1;
      while (!io.cmd_ready && gap < 50) begin
        @(posedge clk);
        #1;
        gap++;
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    int         idx;
    int         data;
    logic [3:0] x;
    logic       lbl;
    int         sum;
    int         y;
    int         upd;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, y, u, lat, gap, ms, my, mu, a0, r0, n;
    logic [1:0] op;
    int idx;
    logic [7:0] data;
    logic [3:0] x;
    logic lbl;

    tbl[0]  = '{OP_LOAD,  0,    3, 4'b0000, 1'b0,    0, 0, 0};
    tbl[1]  = '{OP_LOAD,  1,   -2, 4'b0000, 1'b0,    0, 0, 0};
    tbl[2]  = '{OP_LOAD,  2,    5, 4'b0000, 1'b0,    0, 0, 0};
    tbl[3]  = '{OP_LOAD,  3,   -7, 4'b0000, 1'b0,    0, 0, 0};
    tbl[4]  = '{OP_LOAD,  4,   -1, 4'b0000, 1'b0,    0, 0, 0};
    tbl[5]  = '{OP_INFER, 0,    0, 4'b0101, 1'b0,    7, 1, 0};
    tbl[6]  = '{OP_INFER, 0,    0, 4'b1010, 1'b0,  -10, 0, 0};
    tbl[7]  = '{OP_TRAIN, 0,    0, 4'b0000, 1'b0,   -1, 0, 0};
    tbl[8]  = '{OP_LOAD,  5,   99, 4'b0000, 1'b0,    0, 0, 0};
    tbl[9]  = '{OP_INFER, 0,    0, 4'b1111, 1'b0,   -2, 0, 0};
    tbl[10] = '{OP_CLEAR, 0,    0, 4'b0000, 1'b0,    0, 0, 0};
    tbl[11] = '{OP_TRAIN, 0,    0, 4'b0011, 1'b1,    0, 0, 1};
    tbl[12] = '{OP_INFER, 0,    0, 4'b0011, 1'b0,    3, 1, 0};
    tbl[13] = '{OP_INFER, 0,    0, 4'b0000, 1'b0,    1, 1, 0};
    tbl[14] = '{OP_LOAD,  0,  127, 4'b0000, 1'b0,    0, 0, 0};
    tbl[15] = '{OP_LOAD,  4, -128, 4'b0000, 1'b0,    0, 0, 0};
    tbl[16] = '{OP_TRAIN, 0,    0, 4'b0001, 1'b1,   -1, 0, 1};
    tbl[17] = '{OP_INFER, 0,    0, 4'b0001, 1'b0,    0, 0, 0};
    tbl[18] = '{OP_INFER, 0,    0, 4'b0000, 1'b0, -127, 0, 0};
    tbl[19] = '{OP_LOAD,  0, -128, 4'b0000, 1'b0,    0, 0, 0};
    tbl[20] = '{OP_LOAD,  4,  127, 4'b0000, 1'b0,    0, 0, 0};
    tbl[21] = '{OP_TRAIN, 0,    0, 4'b0001, 1'b0,   -1, 0, 0};
    tbl[22] = '{OP_INFER, 0,    0, 4'b0001, 1'b0,   -1, 0, 0};
    tbl[23] = '{OP_LOAD,  1,    5, 4'b0000, 1'b0,    0, 0, 0};
    tbl[24] = '{OP_TRAIN, 0,    0, 4'b0011, 1'b0,    4, 1, 1};
    tbl[25] = '{OP_INFER, 0,    0, 4'b0011, 1'b0,    2, 1, 0};

    for (int k = 0; k < 4; k++) mw[k] = 0;
    mb = 0;
    io.cmd_valid = 1'b0; io.cmd_op = OP_LOAD; io.cmd_idx = '0;
    io.cmd_data = '0; io.cmd_x = '0; io.cmd_label = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_res_valid", int'(io.res_valid), 0);
    check("rst_res_y", int'(io.res_y), 0);
    check("rst_res_sum", int'(io.res_sum), 0);
    check("rst_res_upd", int'(io.res_upd), 0);
    check("rst_busy", int'(io.busy), 0);
    check("rst_cmd_ready", int'(io.cmd_ready), 1);

    for (int i = 0; i < NV; i++) begin
      exec(tbl[i].op, tbl[i].idx, 8'(tbl[i].data), tbl[i].x, tbl[i].lbl, s, y, u, lat, gap);
      model_cmd(tbl[i].op, tbl[i].idx, 8'(tbl[i].data), tbl[i].x, tbl[i].lbl, ms, my, mu);
      if (tbl[i].op == OP_INFER || tbl[i].op == OP_TRAIN) begin
        check($sformatf("tbl%0d_sum", i), s, tbl[i].sum);
        check($sformatf("tbl%0d_y", i), y, tbl[i].y);
        check($sformatf("tbl%0d_upd", i), u, tbl[i].upd);
        check($sformatf("tbl%0d_latency", i), lat, 5);
        check($sformatf("tbl%0d_ready_gap", i), gap, (tbl[i].upd != 0) ? 5 : 0);
      end
    end

    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 19));
      op = (n < 6) ? OP_LOAD : (n < 12) ? OP_INFER : (n < 19) ? OP_TRAIN : OP_CLEAR;
      idx = int'($urandom_range(0, 5));
      data = 8'($urandom_range(0, 255));
      x = 4'($urandom_range(0, 15));
      lbl = 1'($urandom_range(0, 1));
      exec(op, idx, data, x, lbl, s, y, u, lat, gap);
      model_cmd(op, idx, data, x, lbl, ms, my, mu);
      if (op == OP_INFER || op == OP_TRAIN) begin
        check($sformatf("rnd%0d_sum", i), s, ms);
        check($sformatf("rnd%0d_y", i), y, my);
        check($sformatf("rnd%0d_upd", i), u, mu);
        check($sformatf("rnd%0d_latency", i), lat, 5);
        check($sformatf("rnd%0d_ready_gap", i), gap, (mu != 0) ? 5 : 0);
      end
    end

    // Reset in the middle of an accumulation: no result, everything cleared.
    exec(OP_LOAD, 0, 8'd9, 4'b0000, 1'b0, s, y, u, lat, gap);
    exec(OP_INFER, 0, 8'd0, 4'b1111, 1'b0, s, y, u, lat, gap);
    @(negedge clk);
    io.cmd_op = OP_INFER; io.cmd_x = 4'b1111; io.cmd_valid = 1'b1;
    r0 = rv_cnt;
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", int'(io.res_valid), 0);
    check("midrst_res_y", int'(io.res_y), 0);
    check("midrst_res_sum", int'(io.res_sum), 0);
    check("midrst_res_upd", int'(io.res_upd), 0);
    check("midrst_busy", int'(io.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_result", rv_cnt - r0, 0);
    for (int k = 0; k < 4; k++) mw[k] = 0;
    mb = 0;
    exec(OP_INFER, 0, 8'd0, 4'b1111, 1'b0, s, y, u, lat, gap);
    check("postrst_sum", s, 0);
    check("postrst_y", y, 0);

    // cmd_valid held through a busy period with a 3-cycle ena stall mid-accumulation.
    exec(OP_LOAD, 2, 8'd6, 4'b0000, 1'b0, s, y, u, lat, gap);
    model_cmd(OP_LOAD, 2, 8'd6, 4'b0000, 1'b0, ms, my, mu);
    exec(OP_LOAD, 4, 8'hFD, 4'b0000, 1'b0, s, y, u, lat, gap);
    model_cmd(OP_LOAD, 4, 8'hFD, 4'b0000, 1'b0, ms, my, mu);
    @(negedge clk);
    io.cmd_op = OP_INFER; io.cmd_x = 4'b0110; io.cmd_label = 1'b0; io.cmd_valid = 1'b1;
    n = 0;
    while (!io.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    a0 = acc_cnt;
    r0 = rv_cnt;
    @(posedge clk);
    #1;
    model_cmd(OP_INFER, 0, 8'd0, 4'b0110, 1'b0, ms, my, mu);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    #1;
    check("stall_cmd_ready", int'(io.cmd_ready), 0);
    check("stall_busy", int'(io.busy), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ena = 1'b1;
    lat = 5;
    #1;
    while (!io.res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    io.cmd_valid = 1'b0;
    check("stall_latency", lat, 8);
    check("stall_sum", int'($signed(io.res_sum)), ms);
    check("stall_y", int'(io.res_y), my);
    repeat (10) @(posedge clk);
    #1;
    check("stall_accepts", acc_cnt - a0, 1);
    check("stall_results", rv_cnt - r0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
